// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs a valid/ready byte stream into big-endian 32-bit words
// and writes them to consecutive word addresses of the instruction memory.
module instr_mem_loader #(
  parameter int DEPTH = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [8:0]  word_count_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        mem_write_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_write_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);
  state_t      state_q, state_d;
  logic [8:0]  remaining_q, remaining_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic        mem_write_q, mem_write_d, done_q, done_d, error_q, error_d;
  logic        legal;
  assign legal = (word_count_i != 9'd0) && (word_count_i <= DEPTH_W);
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    byte_cnt_d  = byte_cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mem_write_d = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        if (legal) begin
          remaining_d = word_count_i;
          byte_cnt_d  = 2'd0;
          addr_d      = 32'd0;
          state_d     = LOAD;
        end else error_d = 1'b1;
      end
      LOAD: if (byte_valid_i) begin
        data_d     = {data_q[23:0], byte_i};
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) begin
          mem_write_d = 1'b1;
          state_d     = WRITE;
        end
      end
      WRITE: begin
        remaining_d = remaining_q - 9'd1;
        // Address stays on the last written word so it never passes 4*DEPTH-4.
        if (remaining_q == 9'd1) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          addr_d  = addr_q + 32'd4;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      remaining_q <= 9'd0;
      byte_cnt_q  <= 2'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      mem_write_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      byte_cnt_q  <= byte_cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mem_write_q <= mem_write_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end
  assign byte_ready_o     = (state_q == LOAD);
  assign busy_o           = (state_q != IDLE);
  assign mem_write_o      = mem_write_q;
  assign mem_address_o    = addr_q;
  assign mem_write_data_o = data_q;
  assign done_o           = done_q;
  assign error_o          = error_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed scenario tasks for instr_mem_loader with a write monitor.
module tb_instr_mem_loader;
  logic        clk, rst_n, start_i, byte_valid_i;
  logic [8:0]  word_count_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o, mem_write_o, busy_o, done_o, error_o;
  logic [31:0] mem_address_o, mem_write_data_o;
  int vectors = 0, miscompares = 0;
  logic [31:0] wr_addr[$], wr_data[$];
  int done_cnt = 0, err_cnt = 0, rdy_viol = 0;

  instr_mem_loader #(.DEPTH(256)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .word_count_i(word_count_i),
    .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
    .mem_write_o(mem_write_o), .mem_address_o(mem_address_o),
    .mem_write_data_o(mem_write_data_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_write_o) begin
      wr_addr.push_back(mem_address_o);
      wr_data.push_back(mem_write_data_o);
      if (byte_ready_o) rdy_viol++;
    end
    if (done_o) done_cnt++;
    if (error_o) err_cnt++;
  end

  function automatic logic [7:0] pat(input int wc, input int k);
    return 8'((k * 37 + wc * 11 + 5) & 255);
  endfunction

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    done_cnt = 0;
    err_cnt  = 0;
    rdy_viol = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      byte_valid_i = 1'b0;
      @(negedge clk);
    end
    t = 0;
    while (byte_ready_o !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t == 50) begin
      vectors++; miscompares++;
      $display("FAIL ready_timeout: byte_ready=%b required 1", byte_ready_o);
    end
    byte_valid_i = 1'b1;
    byte_i = b;
    @(negedge clk);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_o !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    vectors++;
    if (done_o !== 1'b1) begin miscompares++; $display("FAIL done_timeout: done=%b required 1", done_o); end
    vectors++;
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL busy_at_done: busy=%b required 0", busy_o); end
    @(negedge clk);
    vectors++;
    if (done_o !== 1'b0) begin miscompares++; $display("FAIL done_width: done=%b required 0", done_o); end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    vectors++;
    if ({byte_ready_o, mem_write_o, busy_o, done_o, error_o} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b required 00000", {byte_ready_o, mem_write_o, busy_o, done_o, error_o});
    end
    vectors++;
    if (mem_address_o !== 32'd0 || mem_write_data_o !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_bus: addr=%h data=%h required 0/0", mem_address_o, mem_write_data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [7:0] bytes [4] = '{8'h20, 8'h08, 8'h00, 8'h05};
    clear_mon();
    start_i = 1'b1; word_count_i = 9'd1;
    @(negedge clk);
    start_i = 1'b0;
    vectors++;
    if (byte_ready_o !== 1'b1 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL single_load_entry: ready=%b busy=%b required 1/1", byte_ready_o, busy_o);
    end
    byte_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      byte_i = bytes[k];
      @(negedge clk);
    end
    vectors++;
    if (mem_write_o !== 1'b1 || byte_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL single_write_flags: wr=%b ready=%b busy=%b required 1/0/1", mem_write_o, byte_ready_o, busy_o);
    end
    vectors++;
    if (mem_address_o !== 32'h0 || mem_write_data_o !== 32'h20080005) begin
      miscompares++;
      $display("FAIL single_write_bus: addr=%h data=%h required 00000000/20080005", mem_address_o, mem_write_data_o);
    end
    @(negedge clk);
    byte_valid_i = 1'b0;
    vectors++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || mem_write_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done: done=%b busy=%b wr=%b required 1/0/0", done_o, busy_o, mem_write_o);
    end
    @(negedge clk);
    vectors++;
    if (done_o !== 1'b0 || wr_addr.size() != 1) begin
      miscompares++;
      $display("FAIL single_after: done=%b writes=%0d required 0/1", done_o, wr_addr.size());
    end
  endtask

  task automatic load_job(input string name, input int wc, input bit gaps, input bit poke);
    logic [31:0] exp;
    clear_mon();
    start_i = 1'b1; word_count_i = 9'(wc);
    @(negedge clk);
    start_i = 1'b0;
    vectors++;
    if (byte_ready_o !== 1'b1 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_entry: ready=%b busy=%b required 1/1", name, byte_ready_o, busy_o);
    end
    for (int k = 0; k < 4 * wc; k++) begin
      if (poke && k == 2) begin
        byte_valid_i = 1'b0;
        start_i = 1'b1; word_count_i = 9'd5;
        @(negedge clk);
        start_i = 1'b0;
      end
      send_byte(pat(wc, k), gaps ? k % 3 : 0);
    end
    byte_valid_i = 1'b0;
    wait_done();
    vectors++;
    if (wr_addr.size() != wc) begin
      miscompares++;
      $display("FAIL %s_count: writes=%0d required %0d", name, wr_addr.size(), wc);
    end
    for (int i = 0; i < wc && i < wr_addr.size(); i++) begin
      exp = {pat(wc, 4*i), pat(wc, 4*i+1), pat(wc, 4*i+2), pat(wc, 4*i+3)};
      vectors++;
      if (wr_addr[i] !== 32'(4*i) || wr_data[i] !== exp) begin
        miscompares++;
        $display("FAIL %s_word%0d: addr=%h data=%h required %h/%h", name, i, wr_addr[i], wr_data[i], 32'(4*i), exp);
      end
    end
    vectors++;
    if (done_cnt != 1 || rdy_viol != 0) begin
      miscompares++;
      $display("FAIL %s_done_ready: dones=%0d ready_in_write=%0d required 1/0", name, done_cnt, rdy_viol);
    end
    vectors++;
    if (mem_address_o !== 32'(4*(wc-1))) begin
      miscompares++;
      $display("FAIL %s_final_addr: addr=%h required %h", name, mem_address_o, 32'(4*(wc-1)));
    end
  endtask

  task automatic test_error();
    clear_mon();
    for (int j = 0; j < 2; j++) begin
      start_i = 1'b1; word_count_i = (j == 0) ? 9'd0 : 9'd257;
      @(negedge clk);
      start_i = 1'b0;
      vectors++;
      if (error_o !== 1'b1 || busy_o !== 1'b0 || byte_ready_o !== 1'b0) begin
        miscompares++;
        $display("FAIL error_pulse%0d: err=%b busy=%b ready=%b required 1/0/0", j, error_o, busy_o, byte_ready_o);
      end
      @(negedge clk);
      vectors++;
      if (error_o !== 1'b0 || busy_o !== 1'b0) begin
        miscompares++;
        $display("FAIL error_after%0d: err=%b busy=%b required 0/0", j, error_o, busy_o);
      end
    end
    vectors++;
    if (err_cnt != 2 || wr_addr.size() != 0) begin
      miscompares++;
      $display("FAIL error_totals: errors=%0d writes=%0d required 2/0", err_cnt, wr_addr.size());
    end
  endtask

  task automatic test_reset_mid_load();
    clear_mon();
    start_i = 1'b1; word_count_i = 9'd2;
    @(negedge clk);
    start_i = 1'b0;
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    byte_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({byte_ready_o, mem_write_o, busy_o, done_o, error_o} !== 5'b0 || mem_address_o !== 32'd0 || mem_write_data_o !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: flags=%b addr=%h data=%h required 0", {byte_ready_o, mem_write_o, busy_o, done_o, error_o}, mem_address_o, mem_write_data_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (wr_addr.size() != 0 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_nowrite: writes=%0d busy=%b required 0/0", wr_addr.size(), busy_o);
    end
    start_i = 1'b1; word_count_i = 9'd1;
    @(negedge clk);
    start_i = 1'b0;
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 1);
    send_byte(8'hC3, 0);
    send_byte(8'hD4, 2);
    byte_valid_i = 1'b0;
    wait_done();
    vectors++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 32'h0 || wr_data[0] !== 32'hA1B2C3D4) begin
      miscompares++;
      $display("FAIL midreset_reload: writes=%0d addr=%h data=%h required 1/00000000/a1b2c3d4", wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[0] : 32'hx, (wr_data.size() > 0) ? wr_data[0] : 32'hx);
    end
  endtask

  initial begin
    start_i = 1'b0; word_count_i = 9'd0; byte_i = 8'd0; byte_valid_i = 1'b0;
    test_reset();
    test_single();
    load_job("gaps3", 3, 1'b1, 1'b0);
    test_error();
    load_job("start_ignored", 2, 1'b1, 1'b1);
    load_job("full256", 256, 1'b0, 1'b0);
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
